// File: rtl/bridge_mem_responder.sv
// rtl/bridge_mem_responder.sv - Avalon-MM mailbox responder: 256x32 memory, wait states, pipelined reads.
// Optional write protection of the top 16 words via BRIDGE_MEM_DEBUG_PROTECT_EN.
module bridge_mem_responder #(
  parameter int WAIT_CYCLES  = 0,
  parameter int READ_LATENCY = 2,
  parameter int ADDR_W       = 10
) (
  input  logic              clk_clk,
  input  logic              reset_reset,
  input  logic [ADDR_W-1:0] s_bridge_address,
  input  logic              s_bridge_read,
  input  logic              s_bridge_write,
  input  logic [31:0]       s_bridge_writedata,
  input  logic [3:0]        s_bridge_byteenable,
  input  logic              s_bridge_burstcount,
  input  logic              s_bridge_debugaccess,
  output logic              s_bridge_waitrequest,
  output logic [31:0]       s_bridge_readdata,
  output logic              s_bridge_readdatavalid,
  output logic              proto_err
);

  localparam int WORDS = 2 ** (ADDR_W - 2);
  localparam logic [2:0] WAIT_LOAD = 3'(WAIT_CYCLES > 0 ? WAIT_CYCLES - 1 : 0);

  typedef enum logic [1:0] {IDLE, WAIT, ACCEPT} state_t;

  state_t            state, state_d;
  logic [2:0]        cnt, cnt_d;
  logic              req, accept, wait_int;
  logic              rd_acc, wr_acc, wr_blocked;
  logic [ADDR_W-3:0] widx;
  logic [31:0]       mem [WORDS];

  logic [READ_LATENCY-1:0] v_q;
  logic [31:0]             d_q [READ_LATENCY];

  logic unused_inputs;
  assign unused_inputs = ^{s_bridge_address[1:0], s_bridge_burstcount, s_bridge_debugaccess};

  assign req  = s_bridge_read | s_bridge_write;
  assign widx = s_bridge_address[ADDR_W-1:2];

  // cnt holds the number of stall cycles still to go, including the current one
  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    accept   = 1'b0;
    wait_int = 1'b1;
    case (state)
      IDLE: begin
        wait_int = (WAIT_CYCLES != 0);
        if (req) begin
          if (WAIT_CYCLES == 0) begin
            accept = 1'b1;
          end else if (WAIT_CYCLES == 1) begin
            state_d = ACCEPT;
          end else begin
            cnt_d   = WAIT_LOAD;
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (!req) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt - 3'd1;
          if (cnt == 3'd1) state_d = ACCEPT;
        end
      end
      ACCEPT: begin
        wait_int = 1'b0;
        accept   = req;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      state <= IDLE;
      cnt   <= 3'd0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
    end
  end

  assign s_bridge_waitrequest = reset_reset | wait_int;

`ifdef BRIDGE_MEM_DEBUG_PROTECT_EN
  assign wr_blocked = (&widx[ADDR_W-3:ADDR_W-6]) & ~s_bridge_debugaccess;
`else
  assign wr_blocked = 1'b0;
`endif

  // a simultaneous read+write performs only the write
  assign wr_acc = accept & s_bridge_write;
  assign rd_acc = accept & s_bridge_read & ~s_bridge_write;

  always_ff @(posedge clk_clk) begin
    if (wr_acc && !wr_blocked) begin
      for (int b = 0; b < 4; b++) begin
        if (s_bridge_byteenable[b]) mem[widx][8*b +: 8] <= s_bridge_writedata[8*b +: 8];
      end
    end
  end

  // each stage only loads on a valid token, so the last stage holds readdata between strobes
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      v_q       <= '0;
      proto_err <= 1'b0;
      for (int i = 0; i < READ_LATENCY; i++) d_q[i] <= 32'd0;
    end else begin
      v_q[0] <= rd_acc;
      if (rd_acc) d_q[0] <= mem[widx];
      for (int i = 1; i < READ_LATENCY; i++) begin
        v_q[i] <= v_q[i-1];
        if (v_q[i-1]) d_q[i] <= d_q[i-1];
      end
      if (accept && s_bridge_read && s_bridge_write) proto_err <= 1'b1;
    end
  end

  assign s_bridge_readdatavalid = v_q[READ_LATENCY-1];
  assign s_bridge_readdata      = d_q[READ_LATENCY-1];

endmodule

// File: tb/tb_bridge_mem_responder.sv
// tb/tb_bridge_mem_responder.sv - randomized self-checking bench for bridge_mem_responder.
// Two instances: no wait states / latency 2, and 3 wait states / latency 3.
module tb_bridge_mem_responder;

  localparam int W0 = 0, L0 = 2, W1 = 3, L1 = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [9:0]  addr  [2];
  logic        rd    [2];
  logic        wr    [2];
  logic        dbg   [2];
  logic        wreq  [2];
  logic        rdv   [2];
  logic        perr  [2];
  logic [31:0] wdata [2];
  logic [31:0] rdata [2];
  logic [3:0]  be    [2];

  bridge_mem_responder #(.WAIT_CYCLES(W0), .READ_LATENCY(L0), .ADDR_W(10)) dut0 (
    .clk_clk(clk), .reset_reset(rst),
    .s_bridge_address(addr[0]), .s_bridge_read(rd[0]), .s_bridge_write(wr[0]),
    .s_bridge_writedata(wdata[0]), .s_bridge_byteenable(be[0]), .s_bridge_burstcount(1'b1),
    .s_bridge_debugaccess(dbg[0]), .s_bridge_waitrequest(wreq[0]), .s_bridge_readdata(rdata[0]),
    .s_bridge_readdatavalid(rdv[0]), .proto_err(perr[0])
  );

  bridge_mem_responder #(.WAIT_CYCLES(W1), .READ_LATENCY(L1), .ADDR_W(10)) dut1 (
    .clk_clk(clk), .reset_reset(rst),
    .s_bridge_address(addr[1]), .s_bridge_read(rd[1]), .s_bridge_write(wr[1]),
    .s_bridge_writedata(wdata[1]), .s_bridge_byteenable(be[1]), .s_bridge_burstcount(1'b1),
    .s_bridge_debugaccess(dbg[1]), .s_bridge_waitrequest(wreq[1]), .s_bridge_readdata(rdata[1]),
    .s_bridge_readdatavalid(rdv[1]), .proto_err(perr[1])
  );

  int vec_cnt = 0;
  int err_cnt = 0;
  int cyc = 0;

  logic [31:0] mem_m [2][256];
  logic [31:0] last_data [2];
  int          perr_from [2];

  typedef struct {
    int          s;
    int          due;
    logic [31:0] data;
  } exp_t;
  exp_t q[$];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int wait_of(int s);
    return (s == 0) ? W0 : W1;
  endfunction

  function automatic int lat_of(int s);
    return (s == 0) ? L0 : L1;
  endfunction

  task automatic check_eq(string tag, logic [31:0] got, logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_write(int s, logic [9:0] a, logic [31:0] d, logic [3:0] b, logic g);
`ifdef BRIDGE_MEM_DEBUG_PROTECT_EN
    if (a[9:6] == 4'hF && !g) return;
`endif
    for (int i = 0; i < 4; i++)
      if (b[i]) mem_m[s][a[9:2]][8*i +: 8] = d[8*i +: 8];
  endtask

  // holds the request until the expected acceptance cycle; returns at posedge+1 after accept
  task automatic xfer(int s, logic r, logic w, logic [9:0] a, logic [31:0] d, logic [3:0] b);
    exp_t e;
    rd[s] = r; wr[s] = w; addr[s] = a; wdata[s] = d; be[s] = b;
    dbg[s] = 1'($urandom_range(0, 1));
    for (int k = 0; k <= wait_of(s); k++) begin
      @(negedge clk);
      check_eq("waitrequest", 32'(wreq[s]), 32'(k < wait_of(s)));
      if (k == wait_of(s)) begin
        if (r && !w) begin
          e.s = s; e.due = cyc + lat_of(s); e.data = mem_m[s][a[9:2]];
          q.push_back(e);
        end
        if (w) model_write(s, a, d, b, dbg[s]);
        if (r && w && cyc < perr_from[s]) perr_from[s] = cyc;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic idle(int s, int n);
    rd[s] = 1'b0; wr[s] = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset(int n);
    rst = 1'b1;
    q.delete();
    for (int s = 0; s < 2; s++) begin
      perr_from[s] = 32'h7fffffff; last_data[s] = 32'd0; rd[s] = 1'b0; wr[s] = 1'b0;
    end
    repeat (n) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic seq_directed(int s);
    for (int i = 0; i < 256; i++) xfer(s, 1'b0, 1'b1, 10'(i * 4), $urandom, 4'hF);
    if (s == 0) begin
      xfer(0, 1'b0, 1'b1, 10'h010, 32'hDEADBEEF, 4'hF);
      xfer(0, 1'b1, 1'b0, 10'h010, 32'd0, 4'h0);
      xfer(0, 1'b0, 1'b1, 10'h020, 32'h11223344, 4'hF);
      xfer(0, 1'b0, 1'b1, 10'h020, 32'hAABBCCDD, 4'b0101);
      xfer(0, 1'b1, 1'b0, 10'h020, 32'd0, 4'h0);
      for (int i = 0; i < 3; i++) xfer(0, 1'b0, 1'b1, 10'(i * 4), 32'(i + 1), 4'hF);
      for (int i = 0; i < 3; i++) xfer(0, 1'b1, 1'b0, 10'(i * 4), 32'd0, 4'h0);
      idle(0, 4);
      xfer(0, 1'b0, 1'b1, 10'h3FC, 32'hCAFEF00D, 4'hF);
      xfer(0, 1'b1, 1'b0, 10'h3FC, 32'd0, 4'h0);
      xfer(0, 1'b1, 1'b0, 10'h000, 32'd0, 4'h0);
      xfer(0, 1'b0, 1'b1, 10'h0FC, 32'h55555555, 4'h0);
      xfer(0, 1'b1, 1'b0, 10'h0FC, 32'd0, 4'h0);
      idle(0, 3);
      xfer(0, 1'b1, 1'b1, 10'h030, 32'h5, 4'hF);
      idle(0, 3);
      xfer(0, 1'b1, 1'b0, 10'h030, 32'd0, 4'h0);
    end else begin
      xfer(1, 1'b0, 1'b1, 10'h010, 32'h0BADC0DE, 4'hF);
      xfer(1, 1'b1, 1'b0, 10'h010, 32'd0, 4'h0);
      xfer(1, 1'b1, 1'b0, 10'h3FC, 32'd0, 4'h0);
    end
    idle(s, 6);
  endtask

  task automatic rand_ops(int s, int n);
    int op;
    for (int i = 0; i < n; i++) begin
      op = $urandom_range(0, 9);
      if (op < 4)      xfer(s, 1'b0, 1'b1, 10'($urandom), $urandom, 4'($urandom));
      else if (op < 9) xfer(s, 1'b1, 1'b0, 10'($urandom), 32'd0, 4'h0);
      else             idle(s, $urandom_range(1, 3));
    end
    idle(s, 8);
  endtask

  always @(negedge clk) begin
    int   idx;
    logic ev;
    for (int s = 0; s < 2; s++) begin
      if (rst) begin
        check_eq("rst_waitrequest", 32'(wreq[s]), 32'd1);
        check_eq("rst_readdatavalid", 32'(rdv[s]), 32'd0);
        check_eq("rst_proto_err", 32'(perr[s]), 32'd0);
        check_eq("rst_readdata", rdata[s], 32'd0);
      end else begin
        idx = -1;
        foreach (q[i]) if (idx < 0 && q[i].s == s) idx = i;
        ev = (idx >= 0) && (q[idx].due == cyc);
        check_eq("readdatavalid", 32'(rdv[s]), 32'(ev));
        if (ev) begin
          check_eq("readdata", rdata[s], q[idx].data);
          last_data[s] = q[idx].data;
          q.delete(idx);
        end else begin
          check_eq("readdata_hold", rdata[s], last_data[s]);
        end
        check_eq("proto_err", 32'(perr[s]), 32'(cyc > perr_from[s]));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    for (int s = 0; s < 2; s++) begin
      rd[s] = 1'b0; wr[s] = 1'b0; dbg[s] = 1'b0; addr[s] = 10'd0; wdata[s] = 32'd0; be[s] = 4'h0;
      perr_from[s] = 32'h7fffffff; last_data[s] = 32'd0;
    end
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    fork
      seq_directed(0);
      seq_directed(1);
    join
    fork
      rand_ops(0, 300);
      rand_ops(1, 150);
    join
    xfer(0, 1'b1, 1'b0, 10'h040, 32'd0, 4'h0);
    do_reset(2);
    idle(0, 8);
    fork
      rand_ops(0, 100);
      rand_ops(1, 50);
    join
    idle(0, 4);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/bridge_mem_responder.md
Name: bridge_mem_responder

Overview:
- Avalon-MM responder (slave) that terminates the out_bridge master port of a proc_N subsystem.
- Provides a 256 x 32-bit word memory as the shared mailbox between processors.
- Supports configurable wait-state insertion, fixed-latency pipelined reads, byte-enabled writes and burstcount = 1.
- Sits in the top level between a proc_N instance and the interconnect.

Parameters:
- WAIT_CYCLES, 0: waitrequest-high cycles inserted before each transfer is accepted (0..7).
- READ_LATENCY, 2: cycles from read acceptance to readdatavalid (1..4).
- ADDR_W, 10: byte address width; word index is address[ADDR_W-1:2].

Ports:
- clk_clk  in  1  system clock, all logic on rising edge.
- reset_reset  in  1  asynchronous, active-high reset.
- s_bridge_address  in  10  byte address; bits [1:0] ignored.
- s_bridge_read  in  1  read request.
- s_bridge_write  in  1  write request.
- s_bridge_writedata  in  32  write data.
- s_bridge_byteenable  in  4  byte lane enables for writes.
- s_bridge_burstcount  in  1  must be 1; value ignored.
- s_bridge_debugaccess  in  1  debug access qualifier; ignored unless optional feature enabled.
- s_bridge_waitrequest  out  1  stall; request accepted on the cycle it is low.
- s_bridge_readdata  out  32  read return data.
- s_bridge_readdatavalid  out  1  one-cycle strobe qualifying readdata.
- proto_err  out  1  sticky flag: simultaneous read and write seen.

Behaviour:
- Reset (async assert, sync release internally not required):
  - waitrequest=1, readdatavalid=0, readdata=0, proto_err=0.
  - Read pipeline flushed; wait counter=0; FSM=IDLE.
  - Memory contents are not reset.
- FSM states:
  - IDLE: no request. waitrequest = (WAIT_CYCLES != 0). Request present and WAIT_CYCLES=0 -> accept same cycle, stay IDLE. Request present and WAIT_CYCLES>0 -> load counter = WAIT_CYCLES-1, go to WAIT.
  - WAIT: waitrequest=1; counter decrements each cycle; counter=0 -> go to ACCEPT.
  - ACCEPT: waitrequest=0; request accepted at this edge; return to IDLE. A new request is therefore not accepted before WAIT_CYCLES+1 cycles later.
- Master drops its request while in WAIT (protocol violation): return to IDLE, nothing accepted.
- Write acceptance: mem[word] updated per byteenable lane at the accepting edge; other lanes unchanged; byteenable=0 is a no-op.
- Read acceptance:
  - mem[word] sampled at the accepting edge; a write accepted on the previous cycle is visible.
  - Data enters a READ_LATENCY-deep valid/data shift pipeline.
  - readdatavalid=1 exactly READ_LATENCY cycles after the accept edge, for one cycle.
  - readdata is held at its last value when readdatavalid=0.
- Pipelined reads: back-to-back accepts (WAIT_CYCLES=0) return in order, one per cycle, with no bubbles.
- Read pipeline never stalls: waitrequest does not depend on outstanding reads.
- Simultaneous read and write accepted:
  - Write performed, read dropped (no readdatavalid).
  - proto_err set; it clears only on reset.
- Address wrap: only address[9:2] is decoded, so 0x3FC is word 255 and there is no aliasing beyond it.
- Reset mid-operation: in-flight reads are discarded and produce no readdatavalid after reset release.

Optional Feature:
- Macro: BRIDGE_MEM_DEBUG_PROTECT_EN.
- Defined:
  - Words 0xF0-0xFF are write-protected unless s_bridge_debugaccess=1 at acceptance.
  - A protected write is accepted with normal handshake timing but leaves memory unchanged.
  - Reads are unaffected.
- Undefined: debugaccess is ignored; all 256 words are writable.

Test Plan:
- WAIT_CYCLES=0, READ_LATENCY=2: write 0xDEADBEEF to 0x010, then read 0x010 -> waitrequest low both cycles; readdatavalid exactly 2 cycles after the read accept with 0xDEADBEEF.
- Write 0x11223344 then byteenable=4'b0101 write 0xAABBCCDD to 0x020; read -> 0x11BB33DD.
- WAIT_CYCLES=3: hold read on 0x010 -> waitrequest high 3 cycles, low on the 4th; data returns READ_LATENCY cycles after that.
- Reads to 0x000, 0x004, 0x008 on consecutive cycles (preloaded 1, 2, 3) -> readdatavalid high 3 consecutive cycles with 1, 2, 3 in order.
- read=write=1 at 0x030 with data 0x5 -> memory holds 0x5, no readdatavalid, proto_err=1 until reset.
- Assert reset_reset one cycle after a read accept -> no readdatavalid appears; waitrequest=1 and proto_err=0 during reset.
